// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_pkg
// Description : Shared processor definitions for the register-file write
//               arbiter: address/data widths, parameter defaults, arbiter
//               FSM encoding and a one-hot register-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

    localparam int unsigned c_addr_w               = 5;
    localparam int unsigned c_data_w               = 32;
    localparam int unsigned c_num_regs             = 32;
    localparam int unsigned c_default_depth        = 2;
    localparam int unsigned c_default_starve_limit = 4;
    localparam int unsigned c_blk_cnt_w            = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,   // FIFO empty
        ST_WAIT   = 2'd1,   // FIFO non-empty, port taken by WB
        ST_STARVE = 2'd2    // blocked too long, requesting a WB bubble
    } arb_state_t;

    // One-hot decode of a register address; r0 is never reported.
    function automatic logic [c_num_regs-1:0] reg_onehot(input logic [c_addr_w-1:0] addr);
        logic [c_num_regs-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        v[0]    = 1'b0;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_fifo
// Description : Multi-cycle write-request FIFO. Exposes per-entry valid and
//               address vectors so the arbiter can build the pending mask.
// Ports       : clk, reset (async, active-low)
//               push/push_wa/push_wd : enqueue (ignored while full)
//               pop                  : dequeue head (ignored while empty)
//               full, empty, one_left: occupancy flags
//               head_wa, head_wd     : oldest entry
//               entry_valid/entry_wa : per-slot view of storage
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = c_default_depth
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic [c_addr_w-1:0]             push_wa,
    input  logic [c_data_w-1:0]             push_wd,
    input  logic                            pop,
    output logic                            full,
    output logic                            empty,
    output logic                            one_left,
    output logic [c_addr_w-1:0]             head_wa,
    output logic [c_data_w-1:0]             head_wd,
    output logic [DEPTH-1:0]                entry_valid,
    output logic [DEPTH-1:0][c_addr_w-1:0]  entry_wa
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;

    logic [c_addr_w-1:0] r_wa [DEPTH];
    logic [c_data_w-1:0] r_wd [DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                w_push;
    logic                w_pop;

    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign empty    = (r_count == '0);
    assign one_left = (r_count == c_cnt_w'(1));
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign head_wa  = r_wa[r_rd_ptr];
    assign head_wd  = r_wd[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_wa[i] <= '0;
                r_wd[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wa[r_wr_ptr] <= push_wa;
                r_wd[r_wr_ptr] <= push_wd;
                r_wr_ptr       <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the
    // occupancy; pointer arithmetic wraps naturally since DEPTH is 2^n.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [c_ptr_w-1:0] w_offset;
        assign w_offset        = c_ptr_w'(gi) - r_rd_ptr;
        assign entry_valid[gi] = ({1'b0, w_offset} < r_count);
        assign entry_wa[gi]    = r_wa[gi];
    end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Arbitrates the single register-file write port between the
//               writeback stage (always wins) and a FIFO of multi-cycle unit
//               results. Raises stall when MD results starve.
// Ports       : clk, reset (async, active-low)
//               wb_we/wb_wa/wb_wd    : writeback request, never back-pressured
//               md_valid/md_wa/md_wd : MD request, accepted when md_ready
//               md_ready             : FIFO not full
//               we/wa3/wd3           : registered register-file write port
//               pending              : registers targeted by queued MD entries
//               stall                : registered WB-bubble request
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH        = c_default_depth,
    parameter int unsigned STARVE_LIMIT = c_default_starve_limit
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_we,
    input  logic [c_addr_w-1:0]   wb_wa,
    input  logic [c_data_w-1:0]   wb_wd,
    input  logic                  md_valid,
    input  logic [c_addr_w-1:0]   md_wa,
    input  logic [c_data_w-1:0]   md_wd,
    output logic                  md_ready,
    output logic                  we,
    output logic [c_addr_w-1:0]   wa3,
    output logic [c_data_w-1:0]   wd3,
    output logic [c_num_regs-1:0] pending,
    output logic                  stall
);

    localparam logic [c_blk_cnt_w-1:0] c_starve_lim = c_blk_cnt_w'(STARVE_LIMIT);

    logic                           w_full;
    logic                           w_empty;
    logic                           w_one_left;
    logic [c_addr_w-1:0]            w_head_wa;
    logic [c_data_w-1:0]            w_head_wd;
    logic [DEPTH-1:0]               w_entry_valid;
    logic [DEPTH-1:0][c_addr_w-1:0] w_entry_wa;
    logic                           w_wb_eff;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_drains;
    logic [c_blk_cnt_w-1:0]         w_blk_next;
    arb_state_t                     w_state_next;

    logic                           r_we;
    logic [c_addr_w-1:0]            r_wa3;
    logic [c_data_w-1:0]            r_wd3;
    logic [c_blk_cnt_w-1:0]         r_blk_cnt;
    arb_state_t                     r_state;

    // A WB write to r0 is a no-op and leaves the port free for the FIFO.
    // The pop decision uses current occupancy, so a same-cycle push into an
    // empty FIFO is never bypassed.
    assign w_wb_eff = wb_we && (wb_wa != '0);
    assign w_push   = md_valid && !w_full;
    assign w_pop    = !w_wb_eff && !w_empty;
    assign w_drains = w_pop && w_one_left && !w_push;

    assign md_ready = !w_full;
    assign we       = r_we;
    assign wa3      = r_wa3;
    assign wd3      = r_wd3;
    assign stall    = (r_state == ST_STARVE);

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (w_push),
        .push_wa     (md_wa),
        .push_wd     (md_wd),
        .pop         (w_pop),
        .full        (w_full),
        .empty       (w_empty),
        .one_left    (w_one_left),
        .head_wa     (w_head_wa),
        .head_wd     (w_head_wd),
        .entry_valid (w_entry_valid),
        .entry_wa    (w_entry_wa)
    );

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) begin
                pending = pending | reg_onehot(w_entry_wa[i]);
            end
        end
    end

    always_comb begin
        w_blk_next = r_blk_cnt;
        if (w_pop) begin
            w_blk_next = '0;
        end else if (!w_empty && (r_blk_cnt < c_starve_lim)) begin
            w_blk_next = r_blk_cnt + 1'b1;
        end
    end

    // STARVE is entered on the same edge the counter reaches the limit so
    // that stall rises after exactly STARVE_LIMIT blocked cycles.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wb_eff && (w_push || !w_empty)) begin
                    w_state_next = (w_blk_next == c_starve_lim) ? ST_STARVE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_drains) begin
                    w_state_next = ST_IDLE;
                end else if (w_blk_next == c_starve_lim) begin
                    w_state_next = ST_STARVE;
                end
            end
            ST_STARVE: begin
                if (w_drains) begin
                    w_state_next = ST_IDLE;
                end else if (w_pop) begin
                    w_state_next = ST_WAIT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_blk_cnt <= '0;
            r_we      <= 1'b0;
            r_wa3     <= '0;
            r_wd3     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_blk_cnt <= w_blk_next;
            r_we      <= 1'b0;
            if (w_wb_eff) begin
                r_we  <= 1'b1;
                r_wa3 <= wb_wa;
                r_wd3 <= wb_wd;
            end else if (w_pop && (w_head_wa != '0)) begin
                r_we  <= 1'b1;
                r_wa3 <= w_head_wa;
                r_wd3 <= w_head_wd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter with
//               default parameters (DEPTH=2, STARVE_LIMIT=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        md_valid;
    logic [4:0]  md_wa;
    logic [31:0] md_wd;
    logic        md_ready;
    logic        we;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pending;
    logic        stall;

    int passed = 0;
    int total  = 0;

    rf_write_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .wb_we    (wb_we),
        .wb_wa    (wb_wa),
        .wb_wd    (wb_wd),
        .md_valid (md_valid),
        .md_wa    (md_wa),
        .md_wd    (md_wd),
        .md_ready (md_ready),
        .we       (we),
        .wa3      (wa3),
        .wd3      (wd3),
        .pending  (pending),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_we"},       32'(we),       32'd0);
        chk({tag, "_wa3"},      32'(wa3),      32'd0);
        chk({tag, "_wd3"},      wd3,           32'd0);
        chk({tag, "_stall"},    32'(stall),    32'd0);
        chk({tag, "_pending"},  pending,       32'd0);
        chk({tag, "_md_ready"}, 32'(md_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b0; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        md_valid = 1'b0; md_wa = '0; md_wd = '0;
        step(); step();
        chk_reset_vals("rst");
        reset = 1'b1;

        // WB only: latency one edge
        wb_we = 1'b1; wb_wa = 5'd10; wb_wd = 32'd420;
        step();
        chk("wb_we",      32'(we),  32'd1);
        chk("wb_wa3",     32'(wa3), 32'd10);
        chk("wb_wd3",     wd3,      32'd420);
        chk("wb_pending", pending,  32'd0);
        wb_we = 1'b0;
        step();
        chk("wb_idle_we",  32'(we),  32'd0);
        chk("wb_idle_wa3", 32'(wa3), 32'd10);

        // MD with WB idle: accept edge, then pop edge
        md_valid = 1'b1; md_wa = 5'd23; md_wd = 32'd143;
        chk("md_ready_empty", 32'(md_ready), 32'd1);
        step();
        md_valid = 1'b0;
        chk("md_pend23",   pending,  32'h0080_0000);
        chk("md_no_bypass", 32'(we), 32'd0);
        step();
        chk("md_we",      32'(we),  32'd1);
        chk("md_wa3",     32'(wa3), 32'd23);
        chk("md_wd3",     wd3,      32'd143);
        chk("md_pend_clr", pending, 32'd0);
        step();
        chk("md_after_we", 32'(we), 32'd0);

        // Full FIFO with WB busy; ordering preserved
        wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h55;
        md_valid = 1'b1; md_wa = 5'd7; md_wd = 32'h77;
        step();
        md_wa = 5'd8; md_wd = 32'h88;
        step();
        chk("full_ready",   32'(md_ready), 32'd0);
        chk("full_pending", pending,       32'h180);
        md_wa = 5'd9; md_wd = 32'h99;
        step();
        chk("full_held_ready", 32'(md_ready), 32'd0);
        chk("full_held_pend",  pending,       32'h180);
        chk("full_wb_wa3",     32'(wa3),      32'd5);
        chk("full_no_stall",   32'(stall),    32'd0);
        wb_we = 1'b0;
        step();
        chk("pop1_wa3",   32'(wa3),      32'd7);
        chk("pop1_wd3",   wd3,           32'h77);
        chk("pop1_ready", 32'(md_ready), 32'd1);
        step();
        md_valid = 1'b0;
        chk("pop2_wa3",  32'(wa3), 32'd8);
        chk("pop2_wd3",  wd3,      32'h88);
        chk("pop2_pend", pending,  32'h200);
        step();
        chk("pop3_we",   32'(we),  32'd1);
        chk("pop3_wa3",  32'(wa3), 32'd9);
        chk("pop3_wd3",  wd3,      32'h99);
        chk("pop3_pend", pending,  32'd0);
        step();
        chk("drained_we", 32'(we), 32'd0);

        // Starvation: WB holds the port
        wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h33;
        md_valid = 1'b1; md_wa = 5'd2; md_wd = 32'd2152;
        step();
        md_valid = 1'b0;
        step(); step(); step();
        chk("starve_pre_stall", 32'(stall), 32'd0);
        step();
        chk("starve_stall",   32'(stall), 32'd1);
        chk("starve_wb_wins", 32'(wa3),   32'd3);
        chk("starve_pend",    pending,    32'h4);
        wb_we = 1'b0;
        step();
        chk("starve_we",    32'(we),    32'd1);
        chk("starve_wa3",   32'(wa3),   32'd2);
        chk("starve_wd3",   wd3,        32'd2152);
        chk("starve_clear", 32'(stall), 32'd0);

        // Register 0: WB write ignored, MD entry consumed without a write
        wb_we = 1'b1; wb_wa = 5'd0; wb_wd = 32'hdead;
        md_valid = 1'b1; md_wa = 5'd0; md_wd = 32'hbeef;
        step();
        wb_we = 1'b0; md_valid = 1'b0;
        chk("r0_wb_we",  32'(we), 32'd0);
        chk("r0_pend",   pending, 32'd0);
        step();
        chk("r0_md_we",  32'(we),  32'd0);
        chk("r0_hold",   32'(wa3), 32'd2);
        md_valid = 1'b1; md_wa = 5'd4; md_wd = 32'h44;
        step();
        md_valid = 1'b0;
        step();
        chk("r0_next_we",  32'(we),  32'd1);
        chk("r0_next_wa3", 32'(wa3), 32'd4);
        chk("r0_next_wd3", wd3,      32'h44);

        // Reset in the middle of a starved, full FIFO
        wb_we = 1'b1; wb_wa = 5'd6; wb_wd = 32'h66;
        md_valid = 1'b1; md_wa = 5'd11; md_wd = 32'hB1;
        step();
        md_wa = 5'd12; md_wd = 32'hB2;
        step();
        md_valid = 1'b0;
        step(); step(); step();
        chk("mid_stall",   32'(stall),    32'd1);
        chk("mid_ready",   32'(md_ready), 32'd0);
        chk("mid_pending", pending,       32'h1800);
        #2;
        reset = 1'b0;
        wb_we = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        step();
        reset = 1'b1;
        step();
        chk("post_rst_we1",   32'(we), 32'd0);
        chk("post_rst_pend1", pending, 32'd0);
        step();
        chk("post_rst_we2",   32'(we),  32'd0);
        chk("post_rst_wa3",   32'(wa3), 32'd0);

        // First grant after reset
        wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'h11;
        step();
        wb_we = 1'b0;
        chk("first_we",  32'(we),  32'd1);
        chk("first_wa3", 32'(wa3), 32'd1);
        chk("first_wd3", wd3,      32'h11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: multi-cycle (MD) write-request FIFO entries; power of two, at least 2.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive blocked cycles before stall is raised; range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wb_we, wb_wa, wb_wd  input  1/5/32  writeback-stage write request; never back-pressured.
REQ-006 md_valid, md_wa, md_wd  input  1/5/32  multi-cycle unit write request.
REQ-007 md_ready  output  1  FIFO can accept an MD request this cycle.
REQ-008 we, wa3, wd3  output  1/5/32  registered drive of the register-file write port.
REQ-009 pending  output  32  bit n set while any FIFO entry targets register n; used by decode hazard logic.
REQ-010 stall  output  1  registered request that the pipeline insert one writeback bubble.

Function
REQ-011 An MD transfer occurs on an edge where md_valid and md_ready are both 1; md_ready is 1 exactly when the FIFO is not full, regardless of a same-cycle pop.
REQ-012 Grant each cycle: an effective WB write (wb_we=1 and wb_wa!=0) wins; otherwise the FIFO head is popped if the FIFO is non-empty; otherwise the port is idle.
REQ-013 Port outputs register the granted request: we/wa3/wd3 reflect the grant one edge after it; when idle, we=0 and wa3/wd3 hold their previous values.
REQ-014 The MD path has a minimum latency of 2 edges, from the accept edge to we=1 with that data; WB latency is exactly 1 edge.
REQ-015 WB or MD writes to register 0 are never driven: a WB write to 0 counts as idle; an MD entry to 0 is accepted and popped but produces we=0.
REQ-016 FIFO order is strict FIFO; push and pop on the same edge are both performed; count stays within 0..DEPTH.
REQ-017 pending is combinational OR of one-hot(wa) over valid FIFO entries; bit 0 is always 0; a bit clears on the pop edge of the last entry targeting that register.
REQ-018 The arbiter does not resolve WAW ordering between WB and MD; decode stalls on pending.
REQ-019 FSM states: IDLE (FIFO empty), WAIT (non-empty, port taken by WB), STARVE (stall=1).
REQ-020 FSM transitions: IDLE->WAIT on a push while WB owns the port; WAIT->STARVE when the blocked counter reaches STARVE_LIMIT; WAIT/STARVE->IDLE on a pop that empties the FIFO; STARVE->WAIT on a pop leaving the FIFO non-empty.
REQ-021 The blocked counter is 4 bits; it increments on each cycle with FIFO non-empty and no pop, clears on any pop, and saturates at STARVE_LIMIT.
REQ-022 stall is 1 exactly while in STARVE; if wb_we stays 1 during stall, WB still wins and no data is lost.
REQ-023 Simultaneous push into an empty FIFO with an idle WB is not bypassed; the entry pops on the following cycle.

Reset
REQ-024 Asserting reset (low) at any time, including mid-drain, immediately clears FIFO, count, counter and FSM (to IDLE), and forces we=0, wa3=0, wd3=0, stall=0, pending=0, md_ready=1.
REQ-025 The first post-reset grant occurs on the first rising edge after reset deasserts.

Structure
REQ-026 DEPTH/STARVE_LIMIT defaults, the FSM state encoding and the 5-bit register-address width are defined in the shared processor package.
REQ-027 The FIFO is a sub-module, rf_wr_fifo, exposing per-entry valid and address vectors for pending generation.

Verification
REQ-028 WB only: wb_we=1, wb_wa=10, wb_wd=420 -> next edge we=1, wa3=10, wd3=420; pending=0.
REQ-029 MD while WB idle: push wa=23, wd=143 -> pending[23]=1 for one cycle; two edges after accept, we=1, wa3=23, wd3=143, and pending[23] clears.
REQ-030 Starvation: wb_we=1 continuously and one MD entry (wa=2, wd=2152) -> stall=1 after 4 blocked cycles; drop wb_we for one cycle -> we=1, wa3=2, wd3=2152, stall=0.
REQ-031 Full FIFO: two MD pushes with WB busy -> md_ready=0, a third md_valid is held; after one pop md_ready=1 and order is preserved.
REQ-032 Register 0 handling: WB write to wa=0 and MD entry wa=0 -> we stays 0 and the MD entry is consumed.
REQ-033 Reset mid-operation: FIFO holds 2 entries and stall=1, pulse reset low asynchronously -> all outputs immediately take their reset values and no stale write appears after release.
